// File: rtl/seg7_scan_encoder.sv
// Scans NDIG BCD digits onto one active-high 7-segment bus with a one-hot enable; 1-cycle output latency.
// load is accepted only while ready; new values go live at the next frame boundary (SEG7_BLANK_LEADING_ZERO_EN blanks leading zeros).
module seg7_scan_encoder #(
    parameter int NDIG        = 4,
    parameter int REFRESH_DIV = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    output logic              ready,
    input  logic [4*NDIG-1:0] digits,
    output logic              a,
    output logic              b,
    output logic              c,
    output logic              d,
    output logic              e,
    output logic              f,
    output logic              g,
    output logic [NDIG-1:0]   an
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NDIG);

    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic [4*NDIG-1:0] active;
    logic [4*NDIG-1:0] shadow;
    logic              pending;
    logic [6:0]        seg_q;
    logic [NDIG-1:0]   an_q;

    logic              cnt_wrap;
    logic              idx_last;
    logic              frame_end;
    logic              accept;
    logic [3:0]        cur_digit;
    logic              blank;
    logic [6:0]        seg_nxt;

    function automatic logic [6:0] encode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    assign ready     = ~pending;
    assign accept    = load & ready;
    assign cnt_wrap  = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign idx_last  = (idx == IDX_W'(NDIG - 1));
    assign frame_end = cnt_wrap & idx_last;
    assign cur_digit = active[4*idx +: 4];

`ifdef SEG7_BLANK_LEADING_ZERO_EN
    // lz[i]: digit i and every digit above it are zero
    logic [NDIG-1:0] lz;
    always_comb begin
        lz = '0;
        lz[NDIG-1] = (active[4*NDIG-1 -: 4] == 4'd0);
        for (int i = NDIG - 2; i >= 0; i--) begin
            lz[i] = lz[i+1] & (active[4*i +: 4] == 4'd0);
        end
    end
    assign blank = (idx != '0) & lz[idx];
`else
    assign blank = 1'b0;
`endif

    assign seg_nxt = blank ? 7'b0000000 : encode(cur_digit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            idx     <= '0;
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            seg_q   <= '0;
            an_q    <= '0;
        end else begin
            cnt <= cnt_wrap ? '0 : cnt + 1'b1;
            if (cnt_wrap) begin
                idx <= idx_last ? '0 : idx + 1'b1;
            end
            // accept and transfer are mutually exclusive: accept needs pending low
            if (accept) begin
                shadow  <= digits;
                pending <= 1'b1;
            end else if (frame_end && pending) begin
                active  <= shadow;
                pending <= 1'b0;
            end
            seg_q <= seg_nxt;
            an_q  <= {{(NDIG-1){1'b0}}, 1'b1} << idx;
        end
    end

    assign {a, b, c, d, e, f, g} = seg_q;
    assign an = an_q;
endmodule

// File: tb/tb_seg7_scan_encoder.sv
// Directed bench for seg7_scan_encoder with NDIG=4, REFRESH_DIV=4 (frame = 16 cycles).
// Cycle n counts rising edges since reset release; frame boundaries fall on edges 16, 32, 48, ...
module tb_seg7_scan_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        ready;
    logic [15:0] digits = '0;
    logic        a, b, c, d, e, f, g;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    seg7_scan_encoder #(.NDIG(4), .REFRESH_DIV(4)) dut (
        .clk(clk), .rst(rst), .load(load), .ready(ready), .digits(digits),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .an(an)
    );

    wire [6:0] seg = {a, b, c, d, e, f, g};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Stands in for the downstream segment-to-BCD decoder in loopback
    function automatic logic [3:0] seg_decode(input logic [6:0] s);
        case (s)
            7'b1111110: return 4'd0;
            7'b0110000: return 4'd1;
            7'b1101101: return 4'd2;
            7'b1111001: return 4'd3;
            7'b0110011: return 4'd4;
            7'b1011011: return 4'd5;
            7'b1011111: return 4'd6;
            7'b1110000: return 4'd7;
            7'b1111111: return 4'd8;
            7'b1111011: return 4'd9;
            default:    return 4'd15;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic pulse_load(input logic [15:0] v);
        digits = v;
        load   = 1'b1;
        tick();
        load   = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        tick();
        check("rst_an", an, 4'b0000);
        check("rst_seg", seg, 7'b0000000);
        check("rst_ready", ready, 1'b1);
        rst = 1'b0;
        cyc = 0;

        // 1: free-running scan of 0000
        run_to(1);  check("t1_an0", an, 4'b0001); check("t1_seg0", seg, 7'b1111110);
        run_to(5);  check("t1_an1", an, 4'b0010); check("t1_seg1", seg, 7'b1111110);
        run_to(9);  check("t1_an2", an, 4'b0100);
        run_to(13); check("t1_an3", an, 4'b1000); check("t1_seg3", seg, 7'b1111110);
        run_to(17); check("t1_wrap", an, 4'b0001); check("t1_ready", ready, 1'b1);

        // 2: load 1234 in IDLE (accepted edge 18, live after edge 32)
        pulse_load(16'h1234);
        check("t2_ready_low", ready, 1'b0);
        run_to(31); check("t2_old_an", an, 4'b1000); check("t2_old_seg", seg, 7'b1111110);
        check("t2_still_pend", ready, 1'b0);
        run_to(32); check("t2_ready_back", ready, 1'b1);
        run_to(33); check("t2_an0", an, 4'b0001); check("t2_d0", seg, 7'b0110011);
        run_to(37); check("t2_an1", an, 4'b0010); check("t2_d1", seg, 7'b1111001);
        run_to(41); check("t2_an2", an, 4'b0100); check("t2_d2", seg, 7'b1101101);
        run_to(45); check("t2_an3", an, 4'b1000); check("t2_d3", seg, 7'b0110000);

        // 3: 1111 accepted at edge 46; 0005 held on load is ignored until ready
        pulse_load(16'h1111);
        check("t3_ready_low", ready, 1'b0);
        digits = 16'h0005;
        load   = 1'b1;
        tick();               // n=47, edge 47 ignored
        tick();               // n=48, boundary edge: 1111 goes live
        check("t3_ready_back", ready, 1'b1);
        tick();               // n=49, 0005 accepted at edge 49
        load = 1'b0;
        check("t3_accept2", ready, 1'b0);
        check("t3_d0", seg, 7'b0110000);
        run_to(53); check("t3_d1", seg, 7'b0110000);
        run_to(64); check("t3_ready_b2", ready, 1'b1);
        run_to(65); check("t3_5_d0", seg, 7'b1011011);

        // 4: 0..9 on digit 0 through the loopback decoder, then FABC
        pulse_load(16'h0000);
        run_to(69); check("t3_5_d1", seg, 7'b1111110);
        for (int v = 0; v < 10; v++) begin
            run_to(81 + 16*v);
            check($sformatf("t4_dec0_%0d", v), {28'd0, seg_decode(seg)}, v);
            check($sformatf("t4_an_%0d", v), an, 4'b0001);
            pulse_load((v == 9) ? 16'hFABC : 16'(v + 1));
            run_to(85 + 16*v);
            check($sformatf("t4_dec1_%0d", v), {28'd0, seg_decode(seg)}, 0);
        end
        run_to(241); check("t4_blank0", seg, 7'b0000000); check("t4_blank_an0", an, 4'b0001);
        run_to(245); check("t4_blank1", seg, 7'b0000000);
        run_to(249); check("t4_blank2", seg, 7'b0000000);
        run_to(253); check("t4_blank3", seg, 7'b0000000); check("t4_blank_an3", an, 4'b1000);

        // 5: reset while 1234 is pending
        run_to(257);
        pulse_load(16'h1234);
        run_to(260);
        check("t5_pending", ready, 1'b0);
        rst = 1'b1;
        #1;
        check("t5_async_an", an, 4'b0000);
        check("t5_async_seg", seg, 7'b0000000);
        check("t5_async_ready", ready, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
        run_to(1);  check("t5_d0", seg, 7'b1111110); check("t5_an0", an, 4'b0001);
        run_to(5);  check("t5_d1", seg, 7'b1111110);
        run_to(9);  check("t5_d2", seg, 7'b1111110);
        run_to(13); check("t5_d3", seg, 7'b1111110);
        run_to(17); check("t5_frame2", seg, 7'b1111110); check("t5_ready", ready, 1'b1);
        run_to(33); check("t5_frame3", seg, 7'b1111110);

        // 6: leading-zero handling for 0070 (live after edge 48)
        pulse_load(16'h0070);
        run_to(49); check("t6_d0", seg, 7'b1111110);
        run_to(53); check("t6_d1", seg, 7'b1110000);
`ifdef SEG7_BLANK_LEADING_ZERO_EN
        run_to(57); check("t6_d2", seg, 7'b0000000); check("t6_an2", an, 4'b0100);
        run_to(61); check("t6_d3", seg, 7'b0000000); check("t6_an3", an, 4'b1000);
`else
        run_to(57); check("t6_d2", seg, 7'b1111110); check("t6_an2", an, 4'b0100);
        run_to(61); check("t6_d3", seg, 7'b1111110); check("t6_an3", an, 4'b1000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
